// File: rtl/fir_out_requant.sv
// Rounds/saturates FIR results to OUT_W, keeps 1 of DEC, and queues them in a show-ahead FIFO; 2 cycles din->dout.
// Backpressure via dout_ready: a kept sample arriving at a full FIFO with no pop is dropped and flagged on ovf.
module fir_out_requant #(
  parameter int IN_W  = 29,
  parameter int OUT_W = 12,
  parameter int SHIFT = 11,
  parameter int DEC   = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [IN_W-1:0]  din,
  input  logic             clr_ovf,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             sat,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam logic [IN_W:0]  RND      = (IN_W + 1)'(1) << (SHIFT - 1);
  localparam logic [PW-1:0]  PH_MAX   = PW'(DEC - 1);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] w_sum;
  logic signed [IN_W:0] w_shr;
  logic [IN_W-OUT_W+1:0] w_hi;
  logic                  w_clip;
  logic [OUT_W-1:0]      w_sat_dat;
  logic                  w_push_req;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  logic [PW-1:0]      r_phase;
  logic               r_s1_vld;
  logic               r_s1_keep;
  logic [IN_W:0]      r_s1_dat;
  logic               r_sat;
  logic               r_ovf;
  logic [OUT_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wr;
  logic [AW-1:0]      r_rd;
  logic [AW:0]        r_cnt;

  // One extra bit of headroom so the rounding add cannot wrap.
  assign w_sum = {din[IN_W-1], din} + RND;
  assign w_shr = w_sum >>> SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_keep <= 1'b0;
      r_s1_dat  <= '0;
    end else begin
      r_s1_vld <= din_valid;
      if (din_valid) begin
        r_s1_dat  <= w_shr;
        r_s1_keep <= (r_phase == '0);
        r_phase   <= (r_phase == PH_MAX) ? '0 : r_phase + 1'b1;
      end
    end
  end

  // In range only when every bit above the output sign bit matches it.
  assign w_hi      = r_s1_dat[IN_W:OUT_W-1];
  assign w_clip    = ~((&w_hi) | ~(|w_hi));
  assign w_sat_dat = w_clip ? (r_s1_dat[IN_W] ? SAT_NEG : SAT_POS) : r_s1_dat[OUT_W-1:0];

  assign w_push_req = r_s1_vld & r_s1_keep;
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == FULL_CNT);
  assign w_pop      = ~w_empty & dout_ready;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_sat <= w_push_req & w_clip;
      if (w_push) begin
        r_mem[r_wr] <= w_sat_dat;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign dout_valid = ~w_empty;
  assign dout       = w_empty ? '0 : r_mem[r_rd];
  assign sat        = r_sat;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: a DEC=1 and a DEC=2 instance share stimulus, each checked
// every cycle against a queue-based model plus hand-computed directed expectations.
module tb_fir_out_requant;

  localparam int IN_W  = 29;
  localparam int OUT_W = 12;
  localparam int SHIFT = 11;
  localparam int DEPTH = 4;
  localparam int OMAX  = (1 << (OUT_W - 1)) - 1;
  localparam int OMIN  = -(1 << (OUT_W - 1));

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            din_valid = 1'b0;
  logic [IN_W-1:0] din = '0;
  logic            clr_ovf = 1'b0;
  logic            dout_ready = 1'b0;
  logic [OUT_W-1:0] o_dout [2];
  logic            o_dv  [2];
  logic            o_sat [2];
  logic            o_ovf [2];

  int checks = 0;
  int errors = 0;

  fir_out_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEC(1), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_ovf(clr_ovf),
    .dout(o_dout[0]), .dout_valid(o_dv[0]), .dout_ready(dout_ready), .sat(o_sat[0]), .ovf(o_ovf[0]));

  fir_out_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEC(2), .DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr_ovf(clr_ovf),
    .dout(o_dout[1]), .dout_valid(o_dv[1]), .dout_ready(dout_ready), .sat(o_sat[1]), .ovf(o_ovf[1]));

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: round-half-up divide, clamp, keep every dec-th, bounded queue.
  int  mq [2][$];
  int  s1d [2] = '{0, 0};
  bit  s1v [2] = '{0, 0};
  bit  s1k [2] = '{0, 0};
  int  ph  [2] = '{0, 0};
  bit  sat_e [2] = '{0, 0};
  bit  ovf_e [2] = '{0, 0};

  function automatic int rnd(input logic [IN_W-1:0] x);
    longint v;
    v = longint'($signed(x));
    return int'((v + (longint'(1) << (SHIFT - 1))) >>> SHIFT);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        s1v[i] = 0; s1k[i] = 0; s1d[i] = 0; ph[i] = 0; sat_e[i] = 0; ovf_e[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin : step
        bit pop, ok, drop;
        int v;
        pop = (mq[i].size() != 0) && dout_ready;
        ok = 0; drop = 0; v = 0;
        sat_e[i] = 0;
        if (s1v[i] && s1k[i]) begin
          v = (s1d[i] > OMAX) ? OMAX : (s1d[i] < OMIN) ? OMIN : s1d[i];
          sat_e[i] = (v != s1d[i]);
          if (mq[i].size() < DEPTH || pop) ok = 1; else drop = 1;
        end
        if (clr_ovf) ovf_e[i] = 0;
        if (drop) ovf_e[i] = 1;
        if (pop) void'(mq[i].pop_front());
        if (ok) mq[i].push_back(v);
        s1v[i] = din_valid;
        if (din_valid) begin
          s1d[i] = rnd(din);
          s1k[i] = (ph[i] == 0);
          ph[i]  = (ph[i] + 1) % (i + 1);
        end
      end
    end
  end

  int got [2][$];
  int satcnt [2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n && o_dv[i] && dout_ready) got[i].push_back(int'($signed(o_dout[i])));
      if (o_sat[i]) satcnt[i]++;
      check($sformatf("model_dv[%0d]", i), int'(o_dv[i]), int'(mq[i].size() != 0));
      check($sformatf("model_dout[%0d]", i), int'($signed(o_dout[i])),
            (mq[i].size() != 0) ? mq[i][0] : 0);
      check($sformatf("model_sat[%0d]", i), int'(o_sat[i]), int'(sat_e[i]));
      check($sformatf("model_ovf[%0d]", i), int'(o_ovf[i]), int'(ovf_e[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    clr_ovf = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    got[0].delete(); got[1].delete();
    satcnt[0] = 0; satcnt[1] = 0;
  endtask

  task automatic feed(input int vals[$], input bit gap);
    foreach (vals[k]) begin
      din_valid = 1'b1;
      din = IN_W'(vals[k]);
      tick();
      if (gap) begin
        din_valid = 1'b0;
        tick();
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic cmp_list(input string nm, input int inst, input int exp[$]);
    check({nm, "_len"}, got[inst].size(), exp.size());
    foreach (exp[k])
      check($sformatf("%s[%0d]", nm, k), (k < got[inst].size()) ? got[inst][k] : 32'h7fff_ffff, exp[k]);
    got[inst].delete();
  endtask

  initial begin
    // Rounding with latency pin on the first sample.
    do_reset();
    check("reset_dv", int'(o_dv[0]), 0);
    check("reset_dout", int'(o_dout[0]), 0);
    dout_ready = 1'b1;
    din_valid = 1'b1; din = IN_W'(10240);
    tick();
    din_valid = 1'b0;
    @(negedge clk); check("lat_dv_edge_k", int'(o_dv[0]), 0);
    @(negedge clk); check("lat_dv_edge_k1", int'(o_dv[0]), 1);
    check("lat_dout", int'($signed(o_dout[0])), 5);
    tick();
    feed('{1024, -1024, -1025, 3071}, 1'b0);
    repeat (6) tick();
    cmp_list("round", 0, '{5, 1, 0, -1, 1});
    check("round_sat", satcnt[0], 0);

    // Saturation.
    do_reset();
    dout_ready = 1'b1;
    feed('{134217728, -134217728, 4192256}, 1'b0);
    repeat (6) tick();
    cmp_list("satur", 0, '{2047, -2048, 2047});
    check("satur_pulses", satcnt[0], 2);

    // Decimation, continuous then with idle gaps.
    do_reset();
    dout_ready = 1'b1;
    feed('{2048, 4096, 6144, 8192, 10240, 12288}, 1'b0);
    repeat (6) tick();
    cmp_list("dec_cont", 1, '{1, 3, 5});
    cmp_list("dec1_cont", 0, '{1, 2, 3, 4, 5, 6});
    do_reset();
    dout_ready = 1'b1;
    feed('{2048, 4096, 6144, 8192, 10240, 12288}, 1'b1);
    repeat (6) tick();
    cmp_list("dec_gap", 1, '{1, 3, 5});

    // Backpressure and overflow.
    do_reset();
    dout_ready = 1'b0;
    feed('{2048, 4096, 6144, 8192, 10240, 12288}, 1'b0);
    repeat (3) tick();
    check("bp_dv", int'(o_dv[0]), 1);
    check("bp_head", int'($signed(o_dout[0])), 1);
    check("bp_ovf", int'(o_ovf[0]), 1);
    check("bp_ovf_dec2", int'(o_ovf[1]), 0);
    dout_ready = 1'b1;
    repeat (6) tick();
    cmp_list("bp_drain", 0, '{1, 2, 3, 4});
    cmp_list("bp_drain2", 1, '{1, 3, 5});
    check("bp_empty", int'(o_dv[0]), 0);
    check("bp_ovf_sticky", int'(o_ovf[0]), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("bp_clr", int'(o_ovf[0]), 0);

    // Full FIFO with a pop in the same cycle as the push.
    do_reset();
    dout_ready = 1'b0;
    feed('{2048, 4096, 6144, 8192}, 1'b0);
    din_valid = 1'b1; din = IN_W'(10240);
    tick();
    din_valid = 1'b0;
    dout_ready = 1'b1;
    tick();
    check("fullpop_ovf", int'(o_ovf[0]), 0);
    repeat (6) tick();
    cmp_list("fullpop", 0, '{1, 2, 3, 4, 5});
    check("fullpop_ovf_end", int'(o_ovf[0]), 0);

    // Reset mid-operation; DEC=2 phase is left at 1 beforehand.
    do_reset();
    dout_ready = 1'b1;
    feed('{14336}, 1'b0);
    repeat (4) tick();
    cmp_list("pre_rst", 1, '{7});
    dout_ready = 1'b0;
    feed('{2048, 4096, 6144, 8192}, 1'b0);
    check("pre_rst_dv", int'(o_dv[0]), 1);
    rst_n = 1'b0;
    #1;
    check("rst_dv_now", int'(o_dv[0]), 0);
    check("rst_dv2_now", int'(o_dv[1]), 0);
    check("rst_ovf_now", int'(o_ovf[0]), 0);
    tick(); tick();
    rst_n = 1'b1;
    got[0].delete(); got[1].delete();
    dout_ready = 1'b1;
    din_valid = 1'b1; din = IN_W'(2048);
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    check("post_rst_dv_k", int'(o_dv[0]), 0);
    @(negedge clk);
    check("post_rst_dv", int'(o_dv[0]), 1);
    check("post_rst_dout", int'($signed(o_dout[0])), 1);
    check("post_rst_dv2", int'(o_dv[1]), 1);
    check("post_rst_dout2", int'($signed(o_dout[1])), 1);
    tick();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
